goldschmidt_ctrl: RTL

Sequencing controller for the 16-bit Goldschmidt divider datapath. It drives the datapath's K-source select, operand select and the two result-register enables. The sequence is one IA-scaling pass, then a parameterised number of refinement iterations, each split into an N half and a D half because the datapath has a single shared multiplier. It accepts one division at a time through a start/done/ack handshake, flags divide-by-zero, and supports abort.

---
 rtl/gs_pkg.sv | 64 ++++++
 rtl/gs_iter_counter.sv | 31 +++
 rtl/goldschmidt_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// gs_pkg: types and constants that the Goldschmidt divider sequencing controller
// and its iteration counter share.
//   state_t   controller states: IDLE, N0, D0, NI, DI, DONE
//   ND_*      ndSelect operand-select codes
//   K_*       kSelect K-source codes
//   ctrl_t    bundle of the Moore outputs that one state decodes to
//   decode()  maps a state to its control outputs
package gs_pkg;

  typedef enum logic [2:0] {IDLE, N0, D0, NI, DI, DONE} state_t;

  localparam logic [1:0] ND_D    = 2'd0;
  localparam logic [1:0] ND_N    = 2'd1;
  localparam logic [1:0] ND_NEWD = 2'd2;
  localparam logic [1:0] ND_NEWN = 2'd3;

  localparam logic K_IA   = 1'b0;
  localparam logic K_ITER = 1'b1;

  typedef struct packed {
    logic       k_sel;
    logic [1:0] nd_sel;
    logic       n_en;
    logic       d_en;
    logic       busy;
    logic       done;
  } ctrl_t;

  // Every control output is 0 unless the state explicitly sets it.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      N0: begin
        c.k_sel  = K_IA;
        c.nd_sel = ND_N;
        c.n_en   = 1'b1;
        c.busy   = 1'b1;
      end
      D0: begin
        c.k_sel  = K_IA;
        c.nd_sel = ND_D;
        c.d_en   = 1'b1;
        c.busy   = 1'b1;
      end
      NI: begin
        c.k_sel  = K_ITER;
        c.nd_sel = ND_NEWN;
        c.n_en   = 1'b1;
        c.busy   = 1'b1;
      end
      DI: begin
        c.k_sel  = K_ITER;
        c.nd_sel = ND_NEWD;
        c.d_en   = 1'b1;
        c.busy   = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gs_iter_counter.sv
// gs_iter_counter: counter for the refinement iterations.
//   clk       clock
//   reset     synchronous, active-low
//   clr       clear the count to 0 (a division is accepted)
//   inc       advance the count by 1 (an iteration is complete)
//   last_val  compare value, ITERS-1
//   last      the count equals last_val
module gs_iter_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] last_val,
  output logic             last
);

  logic [CNT_W-1:0] iter_reg;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      iter_reg <= '0;
    end else if (inc) begin
      iter_reg <= iter_reg + 1'b1;
    end
  end

  assign last = (iter_reg == last_val);

endmodule

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequencing controller for the 16-bit Goldschmidt divider.
// A division runs one IA-scaling pass (N0, D0), then ITERS refinement
// iterations (NI, DI). The datapath has a single shared multiplier, so each
// step is split into an N half followed by a D half.
//   clk       clock
//   reset     synchronous, active-low
//   start     request a division (accepted only in IDLE)
//   divZero   the D operand is zero (sampled together with an accepted start)
//   abort     cancel the operation in flight; in DONE it acts as ack
//   ack       the consumer has taken the result
//   kSelect   K source: 0 = IA, 1 = 2 - newD
//   ndSelect  operand: 0 = D, 1 = N, 2 = newD, 3 = newN
//   nEnable   load the N result register
//   dEnable   load the D result register
//   busy      a division is in flight (N0..DI)
//   done      the result is valid; held until ack
//   error     divide-by-zero; meaningful only while done = 1
module goldschmidt_ctrl
  import gs_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       divZero,
  input  logic       abort,
  input  logic       ack,
  output logic       kSelect,
  output logic [1:0] ndSelect,
  output logic       nEnable,
  output logic       dEnable,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

  state_t state_reg;
  state_t state_next;
  logic   err_reg;
  logic   err_next;
  ctrl_t  ctrl_reg;
  logic   iter_last;
  logic   iter_clr;
  logic   iter_inc;

  // abort overrides every other transition, including a start in IDLE.
  assign iter_clr = (state_reg == IDLE) && start && !divZero && !abort;
  assign iter_inc = (state_reg == DI) && !abort && !iter_last;

  gs_iter_counter #(.CNT_W(CNT_W)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .clr      (iter_clr),
    .inc      (iter_inc),
    .last_val (LAST_ITER),
    .last     (iter_last)
  );

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    if (abort) begin
      state_next = IDLE;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = divZero ? DONE : N0;
            err_next   = divZero;
          end
        end
        N0:   state_next = D0;
        D0:   state_next = NI;
        NI:   state_next = DI;
        DI:   state_next = iter_last ? DONE : NI;
        DONE: begin
          if (ack) begin
            state_next = IDLE;
            err_next   = 1'b0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // The outputs are registered as the decode of the state being entered, so
  // they always match the state register without a combinational output path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
      ctrl_reg  <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      ctrl_reg  <= decode(state_next);
    end
  end

  assign kSelect  = ctrl_reg.k_sel;
  assign ndSelect = ctrl_reg.nd_sel;
  assign nEnable  = ctrl_reg.n_en;
  assign dEnable  = ctrl_reg.d_en;
  assign busy     = ctrl_reg.busy;
  assign done     = ctrl_reg.done;
  assign error    = err_reg;

endmodule
